// File: rtl/mem_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mem_port_arbiter                                              |
// | Purpose  : Shares one single-ported RAM between instruction fetch (IF)   |
// |            and the Memory stage (MEM). One access at a time: IDLE picks  |
// |            a winner, ACCESS drives the RAM for LATENCY cycles, RESP      |
// |            pulses the winner's valid. Stall lines tell the pipeline to   |
// |            freeze while a request is outstanding.                        |
// | Macro    : MEM_ARB_RR_EN -- defined: round-robin on contention,          |
// |            undefined: fixed priority (MEM beats IF).                     |
// | Ports    : clk, reset (async, active-low)                                |
// |            if_req/if_addr -> if_valid/if_rdata/stall_if                  |
// |            mem_req/mem_we/mem_addr/mem_wdata                             |
// |                           -> mem_valid/mem_rdata/stall_mem               |
// |            ram_en/ram_we/ram_addr/ram_wdata <- ram_rdata                 |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module mem_port_arbiter #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 16,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  output logic              stall_if,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              mem_valid,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              stall_mem,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam logic [3:0] C_CNT_LOAD = 4'(LATENCY - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [3:0]          r_cnt;
  logic                r_winner;      // 1 = MEM owns the current access
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_if_valid;
  logic                r_mem_valid;
  logic [DATA_W-1:0]   r_if_rdata;
  logic [DATA_W-1:0]   r_mem_rdata;
  logic                w_grant;
  logic                w_grant_mem;
  logic                w_done;

`ifdef MEM_ARB_RR_EN
  // Set when MEM took the most recent grant. Resets to 1 so that IF is the
  // preferred requester for the first contention after reset.
  logic r_last_mem;

  assign w_grant_mem = mem_req & (~if_req | ~r_last_mem);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_last_mem <= 1'b1;
    end else if (w_grant) begin
      r_last_mem <= w_grant_mem;
    end
  end
`else
  assign w_grant_mem = mem_req;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (if_req || mem_req) begin
          w_grant     = 1'b1;
          w_state_nxt = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (r_cnt == 4'd0) begin
          w_done      = 1'b1;
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt       <= 4'd0;
      r_winner    <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_if_valid  <= 1'b0;
      r_mem_valid <= 1'b0;
      r_if_rdata  <= '0;
      r_mem_rdata <= '0;
    end else begin
      // Valid is registered so it is high exactly during the RESP cycle.
      r_if_valid  <= w_done & ~r_winner;
      r_mem_valid <= w_done & r_winner;
      if (w_grant) begin
        r_winner <= w_grant_mem;
        r_we     <= w_grant_mem & mem_we;
        r_addr   <= w_grant_mem ? mem_addr : if_addr;
        r_wdata  <= w_grant_mem ? mem_wdata : '0;
        r_cnt    <= C_CNT_LOAD;
      end else if (r_state == ST_ACCESS && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_done && !r_we) begin
        if (r_winner) begin
          r_mem_rdata <= ram_rdata;
        end else begin
          r_if_rdata  <= ram_rdata;
        end
      end
    end
  end

  // RAM controls decode only registered state; the counter still holds its
  // load value in the first ACCESS cycle, which gates the single write strobe.
  assign ram_en    = (r_state == ST_ACCESS);
  assign ram_we    = ram_en & r_we & (r_cnt == C_CNT_LOAD);
  assign ram_addr  = r_addr;
  assign ram_wdata = r_wdata;

  assign if_valid  = r_if_valid;
  assign if_rdata  = r_if_rdata;
  assign mem_valid = r_mem_valid;
  assign mem_rdata = r_mem_rdata;
  assign stall_if  = if_req & ~r_if_valid;
  assign stall_mem = mem_req & ~r_mem_valid;

endmodule
`default_nettype wire
